// File: rtl/iir_biquad_cascade_tdm.sv
// Time-multiplexed cascade of DF-I biquad sections on one shared datapath.
// Shadow/active coefficient banks, per-stage bypass and sticky saturation flags.
module iir_biquad_cascade_tdm #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA_FRAC   = 15,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18,
    parameter int N_STAGES    = 3,
    parameter int ACC_WIDTH   = DATA_WIDTH + COEFF_WIDTH + 3,
    localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   ready_in,
    input  logic [DATA_WIDTH-1:0]  iir_in,
    input  logic [N_STAGES-1:0]    bypass_mask,
    output logic [DATA_WIDTH-1:0]  iir_out,
    output logic                   valid_out,
    input  logic                   coeff_wr_en,
    input  logic [SW-1:0]          coeff_stage,
    input  logic [2:0]             coeff_idx,
    input  logic [COEFF_WIDTH-1:0] coeff_wdata,
    input  logic                   coeff_commit,
    output logic [COEFF_WIDTH-1:0] coeff_rdata,
    input  logic                   flag_clr,
    output logic [N_STAGES-1:0]    overflow,
    output logic [N_STAGES-1:0]    underflow
);

    typedef enum logic {IDLE, RUN} state_t;

    // product carries DATA_FRAC+COEFF_FRAC fraction bits, output keeps DATA_FRAC
    localparam int SHIFT = (DATA_FRAC + COEFF_FRAC) - DATA_FRAC;
    localparam logic [SW-1:0] LAST  = SW'(N_STAGES - 1);
    localparam logic [SW:0]   N_LIM = (SW + 1)'(N_STAGES);
    localparam logic signed [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(1) << COEFF_FRAC;
    localparam logic signed [ACC_WIDTH-1:0]   RND   = ACC_WIDTH'(1) << (SHIFT - 1);
    localparam logic signed [DATA_WIDTH-1:0]  D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0]  D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0]   Y_MAX = ACC_WIDTH'(D_MAX);
    localparam logic signed [ACC_WIDTH-1:0]   Y_MIN = ACC_WIDTH'(D_MIN);

    state_t state, state_nx;

    logic signed [DATA_WIDTH-1:0]  x_cur;
    logic signed [DATA_WIDTH-1:0]  x1 [N_STAGES];
    logic signed [DATA_WIDTH-1:0]  x2 [N_STAGES];
    logic signed [DATA_WIDTH-1:0]  y1 [N_STAGES];
    logic signed [DATA_WIDTH-1:0]  y2 [N_STAGES];
    logic signed [COEFF_WIDTH-1:0] shadow [N_STAGES][5];
    logic signed [COEFF_WIDTH-1:0] active [N_STAGES][5];
    logic [N_STAGES-1:0] mask_q;
    logic [SW-1:0]       cnt;
    logic                pending;

    logic accept, do_copy, wr_ok, rd_ok;
    logic byp, ovf, unf;
    logic signed [ACC_WIDTH-1:0]  acc, y_full;
    logic signed [DATA_WIDTH-1:0] y_sat;

    assign ready_in = (state == IDLE);
    assign accept   = valid_in && (state == IDLE);
    // a bank swap never lands between the stages of one sample
    assign do_copy  = pending && (state == IDLE) && !valid_in;
    assign wr_ok    = coeff_wr_en && (coeff_idx < 3'd5) && ({1'b0, coeff_stage} < N_LIM);
    assign rd_ok    = (coeff_idx < 3'd5) && ({1'b0, coeff_stage} < N_LIM);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: one clock per stage, then back to IDLE
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (valid_in) state_nx = RUN;
            RUN:     if (cnt == LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // shared biquad datapath for stage cnt, with rounding and saturation
    always_comb begin
        byp = mask_q[cnt];
        acc = ACC_WIDTH'(x_cur)       * ACC_WIDTH'(active[cnt][0])
            + ACC_WIDTH'(x1[cnt])     * ACC_WIDTH'(active[cnt][1])
            + ACC_WIDTH'(x2[cnt])     * ACC_WIDTH'(active[cnt][2])
            - ACC_WIDTH'(y1[cnt])     * ACC_WIDTH'(active[cnt][3])
            - ACC_WIDTH'(y2[cnt])     * ACC_WIDTH'(active[cnt][4]);
        y_full = (acc + RND) >>> SHIFT;
        ovf = !byp && (y_full > Y_MAX);
        unf = !byp && (y_full < Y_MIN);
        if (byp)      y_sat = x_cur;
        else if (ovf) y_sat = D_MAX;
        else if (unf) y_sat = D_MIN;
        else          y_sat = y_full[DATA_WIDTH-1:0];
    end

    // sample sequencing, per-stage history, output and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cur     <= '0;
            mask_q    <= '0;
            cnt       <= '0;
            iir_out   <= '0;
            valid_out <= 1'b0;
            overflow  <= '0;
            underflow <= '0;
            for (int s = 0; s < N_STAGES; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            if (flag_clr) begin
                overflow  <= '0;
                underflow <= '0;
            end
            if (accept) begin
                x_cur  <= iir_in;
                mask_q <= bypass_mask;
                cnt    <= '0;
            end
            if (state == RUN) begin
                x_cur <= y_sat;
                if (byp) begin
                    x1[cnt] <= '0;
                    x2[cnt] <= '0;
                    y1[cnt] <= '0;
                    y2[cnt] <= '0;
                end else begin
                    x2[cnt] <= x1[cnt];
                    x1[cnt] <= x_cur;
                    y2[cnt] <= y1[cnt];
                    y1[cnt] <= y_sat;
                    if (ovf) overflow[cnt]  <= 1'b1;
                    if (unf) underflow[cnt] <= 1'b1;
                end
                if (cnt == LAST) begin
                    iir_out   <= y_sat;
                    valid_out <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // coefficient banks, commit handling and registered readback
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= 1'b0;
            coeff_rdata <= '0;
            for (int s = 0; s < N_STAGES; s++) begin
                for (int k = 0; k < 5; k++) begin
                    shadow[s][k] <= (k == 0) ? UNITY : '0;
                    active[s][k] <= (k == 0) ? UNITY : '0;
                end
            end
        end else begin
            if (do_copy) active <= shadow;
            if (coeff_commit) pending <= 1'b1;
            else if (do_copy) pending <= 1'b0;
            if (wr_ok) shadow[coeff_stage][coeff_idx] <= coeff_wdata;
            coeff_rdata <= rd_ok ? active[coeff_stage][coeff_idx] : '0;
        end
    end

endmodule

// File: tb/tb_iir_biquad_cascade_tdm.sv
// Directed-vector bench for iir_biquad_cascade_tdm (3 stages, Q1.15 data,
// Q2.18 coefficients); expected outputs are hand-derived per test.
module tb_iir_biquad_cascade_tdm;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] iir_in;
    logic [2:0]  bypass_mask;
    logic [15:0] iir_out;
    logic        valid_out;
    logic        coeff_wr_en;
    logic [1:0]  coeff_stage;
    logic [2:0]  coeff_idx;
    logic [19:0] coeff_wdata;
    logic        coeff_commit;
    logic [19:0] coeff_rdata;
    logic        flag_clr;
    logic [2:0]  overflow;
    logic [2:0]  underflow;

    int checks = 0;
    int errors = 0;

    iir_biquad_cascade_tdm dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .ready_in(ready_in),
        .iir_in(iir_in), .bypass_mask(bypass_mask),
        .iir_out(iir_out), .valid_out(valid_out),
        .coeff_wr_en(coeff_wr_en), .coeff_stage(coeff_stage),
        .coeff_idx(coeff_idx), .coeff_wdata(coeff_wdata),
        .coeff_commit(coeff_commit), .coeff_rdata(coeff_rdata),
        .flag_clr(flag_clr), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        coeff_wr_en = 1'b0;
        coeff_commit = 1'b0;
        flag_clr = 1'b0;
        bypass_mask = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr_coeff(input logic [1:0] s, input logic [2:0] i, input logic [19:0] v);
        coeff_wr_en = 1'b1;
        coeff_stage = s;
        coeff_idx = i;
        coeff_wdata = v;
        @(posedge clk); #1;
        coeff_wr_en = 1'b0;
    endtask

    task automatic commit();
        coeff_commit = 1'b1;
        @(posedge clk); #1;
        coeff_commit = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic rd_coeff(input logic [1:0] s, input logic [2:0] i, output logic [19:0] v);
        coeff_stage = s;
        coeff_idx = i;
        @(posedge clk); #1;
        v = coeff_rdata;
    endtask

    // present one sample; m_run / cm are applied during the first RUN cycle
    task automatic send(input logic [15:0] x, input logic [2:0] m, input logic [2:0] m_run,
                        input logic cm, output logic [15:0] y, output int lat);
        valid_in = 1'b1;
        iir_in = x;
        bypass_mask = m;
        @(posedge clk); #1;
        valid_in = 1'b0;
        bypass_mask = m_run;
        coeff_commit = cm;
        lat = 0;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            coeff_commit = 1'b0;
            lat++;
            if (valid_out) begin
                y = iir_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [19:0] v;
        checks++;
        if (ready_in !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b exp 1", ready_in);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out);
        end
        checks++;
        if (iir_out !== 16'h0000) begin
            errors++; $display("FAIL reset_iir_out got %h exp 0000", iir_out);
        end
        checks++;
        if ({overflow, underflow} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b/%b exp 0/0", overflow, underflow);
        end
        rd_coeff(2'd0, 3'd0, v);
        checks++;
        if (v !== 20'h40000) begin
            errors++; $display("FAIL reset_b0 got %h exp 40000", v);
        end
        rd_coeff(2'd2, 3'd4, v);
        checks++;
        if (v !== 20'h00000) begin
            errors++; $display("FAIL reset_a2 got %h exp 00000", v);
        end
    endtask

    task automatic test_identity();
        logic [15:0] vec [5] = '{16'h1234, 16'hFFFB, 16'h7FFF, 16'h8000, 16'h0000};
        logic [15:0] y;
        int lat;
        do_reset();
        foreach (vec[k]) begin
            send(vec[k], 3'b000, 3'b000, 1'b0, y, lat);
            checks++;
            if (y !== vec[k]) begin
                errors++; $display("FAIL identity_out[%0d] got %h exp %h", k, y, vec[k]);
            end
            checks++;
            if (lat !== 3) begin
                errors++; $display("FAIL identity_latency[%0d] got %0d exp 3", k, lat);
            end
        end
        checks++;
        if ({overflow, underflow} !== 6'b0) begin
            errors++; $display("FAIL identity_flags got %b/%b exp 0/0", overflow, underflow);
        end
    endtask

    task automatic test_fir_rounding();
        logic [15:0] xin [5] = '{16'd100, 16'd101, 16'hFFFD, 16'hFFFD, 16'hFFFE};
        logic [15:0] exp [5] = '{16'd50, 16'd101, 16'd49, 16'hFFFD, 16'hFFFE};
        logic [15:0] y;
        int lat;
        do_reset();
        wr_coeff(2'd0, 3'd0, 20'd131072);
        wr_coeff(2'd0, 3'd1, 20'd131072);
        commit();
        foreach (xin[k]) begin
            send(xin[k], 3'b000, 3'b000, 1'b0, y, lat);
            checks++;
            if (y !== exp[k]) begin
                errors++; $display("FAIL fir_round[%0d] got %h exp %h", k, y, exp[k]);
            end
        end
    endtask

    task automatic test_feedback();
        logic [15:0] xin [5] = '{16'd64, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [15:0] exp [5] = '{16'd0, 16'd0, 16'd64, 16'd32, 16'd48};
        logic [15:0] y;
        int lat;
        do_reset();
        wr_coeff(2'd1, 3'd3, 20'(-131072));
        wr_coeff(2'd2, 3'd0, 20'd0);
        wr_coeff(2'd2, 3'd2, 20'd262144);
        wr_coeff(2'd2, 3'd4, 20'(-131072));
        commit();
        foreach (xin[k]) begin
            send(xin[k], 3'b000, 3'b000, 1'b0, y, lat);
            checks++;
            if (y !== exp[k]) begin
                errors++; $display("FAIL feedback[%0d] got %h exp %h", k, y, exp[k]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] xin [5] = '{16'h1234, 16'hFC18, 16'd800, 16'd800, 16'd800};
        logic [2:0]  msk [5] = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b010};
        logic [2:0]  mrn [5] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b010};
        logic [15:0] exp [5] = '{16'h1234, 16'hFC18, 16'd800, 16'd100, 16'd200};
        logic [15:0] y;
        int lat;
        do_reset();
        wr_coeff(2'd0, 3'd0, 20'd131072);
        wr_coeff(2'd1, 3'd0, 20'd131072);
        wr_coeff(2'd2, 3'd0, 20'd131072);
        commit();
        foreach (xin[k]) begin
            send(xin[k], msk[k], mrn[k], 1'b0, y, lat);
            checks++;
            if (y !== exp[k]) begin
                errors++; $display("FAIL bypass[%0d] got %h exp %h", k, y, exp[k]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] y;
        int lat;
        do_reset();
        wr_coeff(2'd0, 3'd0, 20'd521667);
        commit();
        send(16'h7FFF, 3'b000, 3'b000, 1'b0, y, lat);
        checks++;
        if (y !== 16'h7FFF) begin
            errors++; $display("FAIL sat_pos got %h exp 7fff", y);
        end
        checks++;
        if ({overflow, underflow} !== 6'b001_000) begin
            errors++; $display("FAIL sat_pos_flags got %b/%b exp 001/000", overflow, underflow);
        end
        send(16'h8000, 3'b000, 3'b000, 1'b0, y, lat);
        checks++;
        if (y !== 16'h8000) begin
            errors++; $display("FAIL sat_neg got %h exp 8000", y);
        end
        send(16'h0000, 3'b000, 3'b000, 1'b0, y, lat);
        checks++;
        if ({overflow, underflow} !== 6'b001_001) begin
            errors++; $display("FAIL sat_sticky got %b/%b exp 001/001", overflow, underflow);
        end
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        checks++;
        if ({overflow, underflow} !== 6'b0) begin
            errors++; $display("FAIL flag_clr got %b/%b exp 0/0", overflow, underflow);
        end
        // flag event coinciding with flag_clr must leave the flag set
        valid_in = 1'b1;
        iir_in = 16'h7FFF;
        bypass_mask = 3'b000;
        flag_clr = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        checks++;
        if (overflow !== 3'b001) begin
            errors++; $display("FAIL set_beats_clr got %b exp 001", overflow);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_commit_timing();
        logic [15:0] y;
        logic [19:0] v;
        int lat;
        do_reset();
        wr_coeff(2'd0, 3'd0, 20'd131072);
        wr_coeff(2'd1, 3'd3, 20'h12345);
        rd_coeff(2'd1, 3'd3, v);
        checks++;
        if (v !== 20'h00000) begin
            errors++; $display("FAIL shadow_hidden got %h exp 00000", v);
        end
        send(16'd200, 3'b000, 3'b000, 1'b0, y, lat);
        checks++;
        if (y !== 16'd200) begin
            errors++; $display("FAIL pre_commit got %h exp %h", y, 16'd200);
        end
        send(16'd200, 3'b000, 3'b000, 1'b1, y, lat);
        checks++;
        if (y !== 16'd200) begin
            errors++; $display("FAIL commit_in_run got %h exp %h", y, 16'd200);
        end
        send(16'd200, 3'b000, 3'b000, 1'b0, y, lat);
        checks++;
        if (y !== 16'd200) begin
            errors++; $display("FAIL commit_deferred got %h exp %h", y, 16'd200);
        end
        @(posedge clk); #1;
        rd_coeff(2'd1, 3'd3, v);
        checks++;
        if (v !== 20'h12345) begin
            errors++; $display("FAIL readback_a1 got %h exp 12345", v);
        end
        rd_coeff(2'd0, 3'd0, v);
        checks++;
        if (v !== 20'h20000) begin
            errors++; $display("FAIL readback_b0 got %h exp 20000", v);
        end
        rd_coeff(2'd1, 3'd5, v);
        checks++;
        if (v !== 20'h00000) begin
            errors++; $display("FAIL readback_idx5 got %h exp 00000", v);
        end
        send(16'd200, 3'b010, 3'b010, 1'b0, y, lat);
        checks++;
        if (y !== 16'd100) begin
            errors++; $display("FAIL post_commit got %h exp %h", y, 16'd100);
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        do_reset();
        valid_in = 1'b1;
        iir_in = 16'd77;
        bypass_mask = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e = (k % 4 == 0);
            checks++;
            if (ready_in !== e) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b exp %b", k, ready_in, e);
            end
            checks++;
            if (valid_out !== e) begin
                errors++; $display("FAIL b2b_valid[%0d] got %b exp %b", k, valid_out, e);
            end
            if (e) begin
                checks++;
                if (iir_out !== 16'd77) begin
                    errors++; $display("FAIL b2b_data[%0d] got %h exp %h", k, iir_out, 16'd77);
                end
            end
        end
        valid_in = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] y;
        logic [19:0] v;
        int lat;
        int pulses;
        do_reset();
        wr_coeff(2'd0, 3'd0, 20'd131072);
        commit();
        send(16'd500, 3'b000, 3'b000, 1'b0, y, lat);
        checks++;
        if (y !== 16'd250) begin
            errors++; $display("FAIL pre_reset_out got %h exp %h", y, 16'd250);
        end
        valid_in = 1'b1;
        iir_in = 16'd600;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (iir_out !== 16'h0000 || ready_in !== 1'b1) begin
            errors++; $display("FAIL async_reset got out=%h ready=%b exp 0000/1", iir_out, ready_in);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid_out) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++; $display("FAIL reset_discard got %0d pulses exp 0", pulses);
        end
        rd_coeff(2'd0, 3'd0, v);
        checks++;
        if (v !== 20'h40000) begin
            errors++; $display("FAIL reset_coeff got %h exp 40000", v);
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0;
        iir_in = '0;
        bypass_mask = '0;
        coeff_wr_en = 1'b0;
        coeff_stage = '0;
        coeff_idx = '0;
        coeff_wdata = '0;
        coeff_commit = 1'b0;
        flag_clr = 1'b0;
        #2;
        do_reset();
        test_reset();
        test_identity();
        test_fir_rounding();
        test_feedback();
        test_bypass();
        test_saturation();
        test_commit_timing();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
